// File: rtl/matmul_ctrl.sv
// -----------------------------------------------------------------------------
// matmul_ctrl
//   Sequencer for an N x K by K x M matrix multiply. It walks the result
//   matrix row-major (i over rows, j over columns). For every result element
//   it issues K operand reads/accumulates (k loop), then one result write.
//   All outputs are decoded from the registered state and the i/j/k counters.
//   The only input-to-output paths are rd_en_o/acc_en_o/acc_clr_o, which are
//   gated by mem_ready_i.
//
// Optional feature:
//   MATMUL_CTRL_CYCCNT_EN - when defined, cycles_o counts busy cycles
//   (cleared on accepted start, saturating at 16'hFFFF). When undefined,
//   cycles_o is tied to zero and no counter register exists.
//
// Ports:
//   clk_i        in   rising-edge clock
//   rst_ni       in   asynchronous active-low reset
//   start_i      in   operation request (honoured in IDLE only)
//   abort_i      in   cancel; forces IDLE next cycle, wins over start_i
//   dim_n_i      in   DW  rows of A / rows of C
//   dim_k_i      in   DW  cols of A / rows of B
//   dim_m_i      in   DW  cols of B / cols of C
//   mem_ready_i  in   operand memories can accept a read this cycle
//   busy_o       out  high in MAC and WRITE
//   done_o       out  one-cycle completion pulse
//   err_o        out  sticky dimension error (cleared by next valid start)
//   rd_en_o      out  operand read strobe
//   a_row_o/a_col_o/b_row_o/b_col_o  out IW  operand indices
//   acc_clr_o    out  accumulator clear-and-load (first k of an element)
//   acc_en_o     out  accumulate strobe
//   res_wr_en_o  out  result write strobe
//   res_row_o/res_col_o  out IW  result indices
//   cycles_o     out  16  busy-cycle count
// -----------------------------------------------------------------------------
module matmul_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 64,
  parameter int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
  localparam int IW        = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1,
  localparam int DW        = $clog2(MAX_DIM) + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic [DW-1:0] dim_n_i,
  input  logic [DW-1:0] dim_k_i,
  input  logic [DW-1:0] dim_m_i,
  input  logic          mem_ready_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic          rd_en_o,
  output logic [IW-1:0] a_row_o,
  output logic [IW-1:0] a_col_o,
  output logic [IW-1:0] b_row_o,
  output logic [IW-1:0] b_col_o,
  output logic          acc_clr_o,
  output logic          acc_en_o,
  output logic          res_wr_en_o,
  output logic [IW-1:0] res_row_o,
  output logic [IW-1:0] res_col_o,
  output logic [15:0]   cycles_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [IW-1:0] IDX_ZERO = IW'(0);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [DW-1:0] DIM_ZERO = DW'(0);
  localparam logic [DW-1:0] DIM_ONE  = DW'(1);
  localparam logic [DW-1:0] DIM_MAX  = DW'(MAX_DIM);

  // A dimension is usable when it is non-zero and fits the index range.
  function automatic logic dim_ok(input logic [DW-1:0] dim);
    return (dim != DIM_ZERO) && (dim <= DIM_MAX);
  endfunction

  // True when idx is the last position of a loop of length dim.
  function automatic logic idx_last(input logic [IW-1:0] idx,
                                    input logic [DW-1:0] dim);
    return (DW'(idx) == (dim - DIM_ONE));
  endfunction

  state_t        state_r, state_s;
  logic [IW-1:0] i_r, i_s;
  logic [IW-1:0] j_r, j_s;
  logic [IW-1:0] k_r, k_s;
  logic [DW-1:0] dim_n_r, dim_n_s;
  logic [DW-1:0] dim_k_r, dim_k_s;
  logic [DW-1:0] dim_m_r, dim_m_s;
  logic          err_r, err_s;
  logic          dims_ok_s;
  logic          busy_s;

  assign dims_ok_s = dim_ok(dim_n_i) && dim_ok(dim_k_i) && dim_ok(dim_m_i);

  // Next-state and counter update logic.
  always_comb begin
    state_s = state_r;
    i_s     = i_r;
    j_s     = j_r;
    k_s     = k_r;
    dim_n_s = dim_n_r;
    dim_k_s = dim_k_r;
    dim_m_s = dim_m_r;
    err_s   = err_r;
    if (abort_i) begin
      // Abort wins over everything, including a same-cycle start in IDLE.
      state_s = ST_IDLE;
      i_s     = IDX_ZERO;
      j_s     = IDX_ZERO;
      k_s     = IDX_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            if (dims_ok_s) begin
              dim_n_s = dim_n_i;
              dim_k_s = dim_k_i;
              dim_m_s = dim_m_i;
              i_s     = IDX_ZERO;
              j_s     = IDX_ZERO;
              k_s     = IDX_ZERO;
              err_s   = 1'b0;
              state_s = ST_MAC;
            end else begin
              err_s   = 1'b1;
              state_s = ST_IDLE;
            end
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_MAC: begin
          // A stalled memory freezes the whole walk.
          if (mem_ready_i) begin
            if (idx_last(k_r, dim_k_r)) begin
              state_s = ST_WRITE;
            end else begin
              k_s = k_r + IDX_ONE;
            end
          end else begin
            state_s = ST_MAC;
          end
        end
        ST_WRITE: begin
          k_s = IDX_ZERO;
          if (idx_last(j_r, dim_m_r)) begin
            j_s = IDX_ZERO;
            if (idx_last(i_r, dim_n_r)) begin
              i_s     = IDX_ZERO;
              state_s = ST_DONE;
            end else begin
              i_s     = i_r + IDX_ONE;
              state_s = ST_MAC;
            end
          end else begin
            j_s     = j_r + IDX_ONE;
            state_s = ST_MAC;
          end
        end
        ST_DONE: begin
          state_s = ST_IDLE;
        end
        default: begin
          state_s = ST_IDLE;
          i_s     = IDX_ZERO;
          j_s     = IDX_ZERO;
          k_s     = IDX_ZERO;
        end
      endcase
    end
  end

  // State, index, dimension and error registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
      i_r     <= IDX_ZERO;
      j_r     <= IDX_ZERO;
      k_r     <= IDX_ZERO;
      dim_n_r <= DIM_ZERO;
      dim_k_r <= DIM_ZERO;
      dim_m_r <= DIM_ZERO;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      i_r     <= i_s;
      j_r     <= j_s;
      k_r     <= k_s;
      dim_n_r <= dim_n_s;
      dim_k_r <= dim_k_s;
      dim_m_r <= dim_m_s;
      err_r   <= err_s;
    end
  end

  // Output decode from registered state; indices read as zero when inactive.
  always_comb begin
    busy_s      = 1'b0;
    done_o      = 1'b0;
    rd_en_o     = 1'b0;
    acc_en_o    = 1'b0;
    acc_clr_o   = 1'b0;
    a_row_o     = IDX_ZERO;
    a_col_o     = IDX_ZERO;
    b_row_o     = IDX_ZERO;
    b_col_o     = IDX_ZERO;
    res_wr_en_o = 1'b0;
    res_row_o   = IDX_ZERO;
    res_col_o   = IDX_ZERO;
    case (state_r)
      ST_MAC: begin
        busy_s    = 1'b1;
        rd_en_o   = mem_ready_i;
        acc_en_o  = mem_ready_i;
        acc_clr_o = mem_ready_i && (k_r == IDX_ZERO);
        a_row_o   = i_r;
        a_col_o   = k_r;
        b_row_o   = k_r;
        b_col_o   = j_r;
      end
      ST_WRITE: begin
        busy_s      = 1'b1;
        res_wr_en_o = 1'b1;
        res_row_o   = i_r;
        res_col_o   = j_r;
      end
      ST_DONE: begin
        done_o = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  assign busy_o = busy_s;
  assign err_o  = err_r;

`ifdef MATMUL_CTRL_CYCCNT_EN
  logic        start_acc_s;
  logic [15:0] cycles_r;

  assign start_acc_s = (state_r == ST_IDLE) && !abort_i && start_i && dims_ok_s;

  // Busy-cycle counter: restarts on an accepted start, saturates, then holds.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycles_r <= 16'h0000;
    end else if (start_acc_s) begin
      cycles_r <= 16'h0000;
    end else if (busy_s && (cycles_r != 16'hFFFF)) begin
      cycles_r <= cycles_r + 16'h0001;
    end else begin
      cycles_r <= cycles_r;
    end
  end

  assign cycles_o = cycles_r;
`else
  assign cycles_o = 16'h0000;
`endif

endmodule

// File: tb/tb_matmul_ctrl.sv
// -----------------------------------------------------------------------------
// tb_matmul_ctrl
//   Directed bench for matmul_ctrl with default parameters (MAX_DIM=2).
//   Each run records per-cycle output traces; cycle c means the c-th clock
//   period after the edge that sampled start_i. Expected traces are
//   hand-computed bit masks (bit c = value in cycle c).
// -----------------------------------------------------------------------------
module tb_matmul_ctrl;

  localparam int IW = 1;
  localparam int DW = 2;

  logic          clk_i;
  logic          rst_ni;
  logic          start_i;
  logic          abort_i;
  logic [DW-1:0] dim_n_i;
  logic [DW-1:0] dim_k_i;
  logic [DW-1:0] dim_m_i;
  logic          mem_ready_i;
  logic          busy_o;
  logic          done_o;
  logic          err_o;
  logic          rd_en_o;
  logic [IW-1:0] a_row_o;
  logic [IW-1:0] a_col_o;
  logic [IW-1:0] b_row_o;
  logic [IW-1:0] b_col_o;
  logic          acc_clr_o;
  logic          acc_en_o;
  logic          res_wr_en_o;
  logic [IW-1:0] res_row_o;
  logic [IW-1:0] res_col_o;
  logic [15:0]   cycles_o;

  matmul_ctrl dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .dim_n_i     (dim_n_i),
    .dim_k_i     (dim_k_i),
    .dim_m_i     (dim_m_i),
    .mem_ready_i (mem_ready_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .rd_en_o     (rd_en_o),
    .a_row_o     (a_row_o),
    .a_col_o     (a_col_o),
    .b_row_o     (b_row_o),
    .b_col_o     (b_col_o),
    .acc_clr_o   (acc_clr_o),
    .acc_en_o    (acc_en_o),
    .res_wr_en_o (res_wr_en_o),
    .res_row_o   (res_row_o),
    .res_col_o   (res_col_o),
    .cycles_o    (cycles_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int vec_cnt    = 0;
  int miscmp_cnt = 0;

  // per-cycle traces and per-cycle input patterns
  logic [31:0]   tr_busy, tr_done, tr_err, tr_rden, tr_acen, tr_clr, tr_wr;
  logic [IW-1:0] tr_arow [0:31];
  logic [IW-1:0] tr_acol [0:31];
  logic [IW-1:0] tr_brow [0:31];
  logic [IW-1:0] tr_bcol [0:31];
  logic [IW-1:0] tr_rrow [0:31];
  logic [IW-1:0] tr_rcol [0:31];
  logic [15:0]   tr_cyc  [0:31];
  logic [31:0]   pat_rdy, pat_abort, pat_start;

`ifdef MATMUL_CTRL_CYCCNT_EN
  localparam bit CYC_EN = 1'b1;
`else
  localparam bit CYC_EN = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscmp_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_op(input logic [DW-1:0] n, input logic [DW-1:0] k,
                          input logic [DW-1:0] m, input logic abrt);
    @(negedge clk_i);
    dim_n_i     = n;
    dim_k_i     = k;
    dim_m_i     = m;
    start_i     = 1'b1;
    abort_i     = abrt;
    mem_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    abort_i = 1'b0;
  endtask

  task automatic run_cycles(input int n);
    tr_busy = '0; tr_done = '0; tr_err = '0; tr_rden = '0;
    tr_acen = '0; tr_clr = '0; tr_wr = '0;
    for (int c = 1; c <= n; c++) begin
      if (c > 1) begin
        @(posedge clk_i);
        #1;
      end
      mem_ready_i = pat_rdy[c];
      abort_i     = pat_abort[c];
      start_i     = pat_start[c];
      @(negedge clk_i);
      tr_busy[c] = busy_o;
      tr_done[c] = done_o;
      tr_err[c]  = err_o;
      tr_rden[c] = rd_en_o;
      tr_acen[c] = acc_en_o;
      tr_clr[c]  = acc_clr_o;
      tr_wr[c]   = res_wr_en_o;
      tr_arow[c] = a_row_o;
      tr_acol[c] = a_col_o;
      tr_brow[c] = b_row_o;
      tr_bcol[c] = b_col_o;
      tr_rrow[c] = res_row_o;
      tr_rcol[c] = res_col_o;
      tr_cyc[c]  = cycles_o;
    end
    mem_ready_i = 1'b1;
    abort_i     = 1'b0;
    start_i     = 1'b0;
    pat_rdy     = '1;
    pat_abort   = '0;
    pat_start   = '0;
  endtask

  task automatic check_masks(input string tag, input int n,
                             input logic [31:0] busy_m, input logic [31:0] wr_m,
                             input logic [31:0] clr_m, input logic [31:0] rden_m,
                             input logic [31:0] done_m);
    for (int c = 1; c <= n; c++) begin
      chk($sformatf("%s busy c%0d", tag, c), 32'(tr_busy[c]), 32'(busy_m[c]));
      chk($sformatf("%s done c%0d", tag, c), 32'(tr_done[c]), 32'(done_m[c]));
      chk($sformatf("%s wr c%0d", tag, c),   32'(tr_wr[c]),   32'(wr_m[c]));
      chk($sformatf("%s clr c%0d", tag, c),  32'(tr_clr[c]),  32'(clr_m[c]));
      chk($sformatf("%s rden c%0d", tag, c), 32'(tr_rden[c]), 32'(rden_m[c]));
      chk($sformatf("%s acen c%0d", tag, c), 32'(tr_acen[c]), 32'(rden_m[c]));
    end
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, " busy"},  32'(busy_o),      32'd0);
    chk({tag, " done"},  32'(done_o),      32'd0);
    chk({tag, " err"},   32'(err_o),       32'd0);
    chk({tag, " rden"},  32'(rd_en_o),     32'd0);
    chk({tag, " acen"},  32'(acc_en_o),    32'd0);
    chk({tag, " clr"},   32'(acc_clr_o),   32'd0);
    chk({tag, " wr"},    32'(res_wr_en_o), 32'd0);
    chk({tag, " idx"},   32'({a_row_o, a_col_o, b_row_o, b_col_o, res_row_o, res_col_o}), 32'd0);
    chk({tag, " cycles"}, 32'(cycles_o),   32'd0);
  endtask

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; abort_i = 1'b0; mem_ready_i = 1'b1;
    dim_n_i = 2'd0; dim_k_i = 2'd0; dim_m_i = 2'd0;
    pat_rdy = '1; pat_abort = '0; pat_start = '0;
    #12;
    check_quiet("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;

    // 2x2x2 with a stray start mid-run (must be ignored)
    pat_start[5] = 1'b1;
    start_op(2'd2, 2'd2, 2'd2, 1'b0);
    run_cycles(16);
    check_masks("n2", 16, 32'h1FFE, 32'h1248, 32'h0492, 32'h0DB6, 32'h2000);
    chk("n2 res c3",  32'({tr_rrow[3],  tr_rcol[3]}),  32'd0);
    chk("n2 res c6",  32'({tr_rrow[6],  tr_rcol[6]}),  32'd1);
    chk("n2 res c9",  32'({tr_rrow[9],  tr_rcol[9]}),  32'd2);
    chk("n2 res c12", 32'({tr_rrow[12], tr_rcol[12]}), 32'd3);
    chk("n2 ab c1",  32'({tr_arow[1],  tr_acol[1],  tr_brow[1],  tr_bcol[1]}),  32'h0);
    chk("n2 ab c2",  32'({tr_arow[2],  tr_acol[2],  tr_brow[2],  tr_bcol[2]}),  32'h6);
    chk("n2 ab c4",  32'({tr_arow[4],  tr_acol[4],  tr_brow[4],  tr_bcol[4]}),  32'h1);
    chk("n2 ab c5",  32'({tr_arow[5],  tr_acol[5],  tr_brow[5],  tr_bcol[5]}),  32'h7);
    chk("n2 ab c7",  32'({tr_arow[7],  tr_acol[7],  tr_brow[7],  tr_bcol[7]}),  32'h8);
    chk("n2 ab c11", 32'({tr_arow[11], tr_acol[11], tr_brow[11], tr_bcol[11]}), 32'hF);
    chk("n2 cycles", 32'(tr_cyc[13]), CYC_EN ? 32'd12 : 32'd0);

    // 1x1x1
    start_op(2'd1, 2'd1, 2'd1, 1'b0);
    run_cycles(5);
    check_masks("n1", 5, 32'h6, 32'h4, 32'h2, 32'h2, 32'h8);
    chk("n1 cycles", 32'(tr_cyc[4]), CYC_EN ? 32'd2 : 32'd0);

    // dimension errors: K=0, then K=3 (> MAX_DIM), then a valid start
    start_op(2'd2, 2'd0, 2'd2, 1'b0);
    run_cycles(4);
    check_masks("k0", 4, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("k0 err c1", 32'(tr_err[1]), 32'd1);
    chk("k0 err c4", 32'(tr_err[4]), 32'd1);
    start_op(2'd2, 2'd3, 2'd2, 1'b0);
    run_cycles(3);
    check_masks("k3", 3, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("k3 err c3", 32'(tr_err[3]), 32'd1);
    start_op(2'd1, 2'd1, 2'd1, 1'b0);
    run_cycles(4);
    chk("errclr c1", 32'(tr_err[1]), 32'd0);
    check_masks("errclr", 4, 32'h6, 32'h4, 32'h2, 32'h2, 32'h8);

    // abort together with start in IDLE: start must not be taken
    start_op(2'd1, 2'd1, 2'd1, 1'b1);
    run_cycles(4);
    check_masks("abst", 4, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);

    // memory stall for 3 cycles during the second MAC
    pat_rdy[2] = 1'b0; pat_rdy[3] = 1'b0; pat_rdy[4] = 1'b0;
    start_op(2'd2, 2'd2, 2'd2, 1'b0);
    run_cycles(18);
    check_masks("stall", 18, 32'hFFFE, 32'h9240, 32'h2482, 32'h6DA2, 32'h10000);
    chk("stall acol c3", 32'(tr_acol[3]), 32'd1);
    chk("stall acol c5", 32'(tr_acol[5]), 32'd1);
    chk("stall res c6",  32'({tr_rrow[6],  tr_rcol[6]}),  32'd0);
    chk("stall res c15", 32'({tr_rrow[15], tr_rcol[15]}), 32'd3);
    chk("stall cycles", 32'(tr_cyc[16]), CYC_EN ? 32'd15 : 32'd0);

    // abort during cycle 5
    pat_abort[5] = 1'b1;
    start_op(2'd2, 2'd2, 2'd2, 1'b0);
    run_cycles(16);
    check_masks("abort", 16, 32'h3E, 32'h8, 32'h12, 32'h36, 32'h0);
    chk("abort cycles", 32'(tr_cyc[8]), CYC_EN ? 32'd5 : 32'd0);

    // asynchronous reset mid-operation
    start_op(2'd2, 2'd2, 2'd2, 1'b0);
    run_cycles(5);
    chk("pre-rst bcol", 32'(b_col_o), 32'd1);
    #1 rst_ni = 1'b0;
    #1 check_quiet("midrst");
    #1 rst_ni = 1'b1;
    start_op(2'd1, 2'd1, 2'd1, 1'b0);
    run_cycles(5);
    check_masks("postrst", 5, 32'h6, 32'h4, 32'h2, 32'h2, 32'h8);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule

// File: doc/matmul_ctrl.md
MATMUL_CTRL -- requirements
Module: matmul_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand element width (informational, sizes nothing here).
REQ-002 Parameter BUS_WIDTH, default 64, APB data bus width.
REQ-003 Parameter MAX_DIM, default BUS_WIDTH/DATA_WIDTH, maximum matrix dimension; derived IW = max(1, clog2(MAX_DIM)), DW = clog2(MAX_DIM)+1.
REQ-004 One clock; reset is asynchronous and active-low: clk_i  input  1  rising-edge clock; rst_ni  input  1  asynchronous active-low reset.
REQ-005 start_i  input  1  operation request, sampled each rising edge.
REQ-006 abort_i  input  1  cancel current operation.
REQ-007 dim_n_i / dim_k_i / dim_m_i  input  DW each  A is N x K, B is K x M, C is N x M.
REQ-008 mem_ready_i  input  1  operand memories able to accept a read this cycle.
REQ-009 busy_o  output  1  operation in progress; done_o  output  1  one-cycle completion pulse; err_o  output  1  sticky dimension error.
REQ-010 rd_en_o  output  1  operand read strobe; a_row_o, a_col_o, b_row_o, b_col_o  output  IW each  operand indices.
REQ-011 acc_clr_o, acc_en_o  output  1 each  accumulator clear-and-load / accumulate strobes.
REQ-012 res_wr_en_o  output  1  result write strobe; res_row_o, res_col_o  output  IW each  result indices.
REQ-013 cycles_o  output  16  busy-cycle count (see Configuration).

Function
REQ-014 The FSM SHALL have states IDLE, MAC, WRITE, DONE; all outputs SHALL be decoded from registered state and index counters i, j, k (no input-to-output combinational path except rd_en_o/acc_en_o gating by mem_ready_i).
REQ-015 IDLE: start_i=1 with all dims in 1..MAX_DIM SHALL latch dims, clear i/j/k, clear err_o, and enter MAC next cycle.
REQ-016 IDLE: start_i=1 with any dim 0 or >MAX_DIM SHALL set err_o, remain in IDLE, and never assert done_o.
REQ-017 MAC: rd_en_o = acc_en_o = mem_ready_i; a=(i,k), b=(k,j); acc_clr_o = acc_en_o AND k==0.
REQ-018 MAC with mem_ready_i=1: k==K-1 -> WRITE, else k increments; with mem_ready_i=0 all state and indices SHALL hold.
REQ-019 WRITE (one cycle): res_wr_en_o=1, res=(i,j); then k=0; if j==M-1 and i==N-1 -> DONE; else if j==M-1 then j=0, i++ -> MAC; else j++ -> MAC.
REQ-020 DONE (one cycle): done_o=1, then IDLE.
REQ-021 busy_o SHALL be 1 in MAC and WRITE only.
REQ-022 Latency: start sampled at edge t0 with mem_ready_i constantly 1 -> first MAC cycle t0+1, done_o high in cycle t0+1+N*M*(K+1).
REQ-023 start_i while not in IDLE SHALL be ignored.
REQ-024 abort_i=1 in any state SHALL force IDLE next cycle, clear i/j/k, suppress done_o; abort_i has priority over start_i in the same cycle.
REQ-025 Outside their active states all strobes SHALL be 0 and all index outputs 0.

Reset
REQ-026 rst_ni low SHALL asynchronously force IDLE, i=j=k=0, latched dims=0, err_o=0, cycles_o=0, and all strobes 0, including mid-operation; no done_o follows reset.

Configuration
REQ-027 With macro MATMUL_CTRL_CYCCNT_EN defined, cycles_o SHALL clear on accepted start, increment each cycle busy_o=1, saturate at 0xFFFF, and hold after done/abort.
REQ-028 Without MATMUL_CTRL_CYCCNT_EN, cycles_o SHALL be constant 0 and no counter register SHALL be synthesized; the port list is unchanged.

Verification
REQ-029 N=M=K=2, start pulse at t0, mem_ready_i=1 -> res writes at (0,0),(0,1),(1,0),(1,1) in cycles t0+3,6,9,12; done_o at t0+13; cycles_o=12 when enabled.
REQ-030 N=M=K=1 -> one MAC with acc_clr_o=1, res_wr_en_o at t0+2, done_o at t0+3.
REQ-031 dim_k_i=0 (or 3 with MAX_DIM=2) -> err_o=1, busy_o stays 0, no done_o; following valid start clears err_o.
REQ-032 N=M=K=2, mem_ready_i=0 for 3 cycles during second MAC -> indices/strobes hold, done_o delayed exactly 3 cycles to t0+16.
REQ-033 abort_i at t0+5 during N=M=K=2 run -> IDLE at t0+6, busy_o=0, no done_o; start_i asserted mid-run is ignored.
REQ-034 rst_ni low asynchronously mid-MAC -> all outputs 0 immediately; after release a new start runs normally.
